wiper_ctrl: RTL and testbench



---
 rtl/wiper_pkg.sv | 26 ++
 rtl/wiper_popcount.sv | 22 ++
 rtl/wiper_ctrl.sv | 131 +++++++++++++
 tb/tb_wiper_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wiper_pkg.sv
// Shared types for the rain-driven wiper controller: FSM state and manual mode encodings.
package wiper_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } wiper_state_t;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    F_OFF  = 2'd1,
    F_SLOW = 2'd2,
    F_FAST = 2'd3
  } wiper_mode_t;

  // Wiper state imposed by a manual mode; AUTO has no forced state and maps to OFF.
  function automatic wiper_state_t forced_state(input wiper_mode_t m);
    case (m)
      F_SLOW:  forced_state = SLOW;
      F_FAST:  forced_state = FAST;
      default: forced_state = OFF;
    endcase
  endfunction

endpackage

// File: rtl/wiper_popcount.sv
// Combinational count of active drop sensors.
module wiper_popcount #(
  parameter int N_SENS = 7
) (
  input  logic [N_SENS-1:0]           drops,
  output logic [$clog2(N_SENS+1)-1:0] num_drops
);

  localparam int CW = $clog2(N_SENS + 1);

  logic [CW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      w_sum = w_sum + CW'(drops[i]);
    end
  end

  assign num_drops = w_sum;

endmodule

// File: rtl/wiper_ctrl.sv
// Rain-driven wiper controller: sample divider, persistence counters and OFF/SLOW/FAST FSM
// with a manual override.
module wiper_ctrl
  import wiper_pkg::*;
#(
  parameter int N_SENS       = 7,
  parameter int SLOW_TH      = 4,
  parameter int FAST_TH      = 6,
  parameter int SLOW_PERSIST = 3,
  parameter int FAST_PERSIST = 2,
  parameter int DOWN_PERSIST = 2,
  parameter int SAMPLE_DIV   = 2
) (
  input  logic                        clk_2,
  input  logic                        reset,
  input  logic [N_SENS-1:0]           drops,
  input  logic [1:0]                  mode,
  output logic [$clog2(N_SENS+1)-1:0] num_drops,
  output logic                        sample_tick,
  output logic [1:0]                  state,
  output logic                        wipe_slow,
  output logic                        wipe_fast
);

  localparam int CW = $clog2(N_SENS + 1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = $clog2(SLOW_PERSIST + 1);
  localparam int FW = $clog2(FAST_PERSIST + 1);
  localparam int NW = $clog2(DOWN_PERSIST + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] SLOW_TH_C = CW'(SLOW_TH);
  localparam logic [CW-1:0] FAST_TH_C = CW'(FAST_TH);
  localparam logic [SW-1:0] SLOW_P_C  = SW'(SLOW_PERSIST);
  localparam logic [FW-1:0] FAST_P_C  = FW'(FAST_PERSIST);
  localparam logic [NW-1:0] DOWN_P_C  = NW'(DOWN_PERSIST);

  logic [DW-1:0] r_div_cnt;
  logic [SW-1:0] r_cnt_slow, w_slow_nxt, w_slow_d;
  logic [FW-1:0] r_cnt_fast, w_fast_nxt, w_fast_d;
  logic [NW-1:0] r_cnt_down, w_down_nxt, w_down_d;
  wiper_state_t  r_state, w_state_d;
  wiper_mode_t   w_mode;
  logic [CW-1:0] w_num;
  logic          w_tick, w_ge_slow, w_ge_fast, w_below;

  wiper_popcount #(.N_SENS(N_SENS)) u_popcount (
    .drops     (drops),
    .num_drops (w_num)
  );

  assign w_tick = (r_div_cnt == DIV_LAST);
  assign w_mode = wiper_mode_t'(mode);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset)                  r_div_cnt <= '0;
    else if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + DW'(1);
  end

  assign w_ge_slow = (w_num >= SLOW_TH_C);
  assign w_ge_fast = (w_num >= FAST_TH_C);

  // "Below" is relative to the entry threshold of the level currently held.
  always_comb begin
    w_below = 1'b0;
    case (r_state)
      SLOW:    w_below = !w_ge_slow;
      FAST:    w_below = !w_ge_fast;
      default: w_below = 1'b0;
    endcase
  end

  assign w_slow_nxt = !w_ge_slow ? '0 : (r_cnt_slow == SLOW_P_C) ? r_cnt_slow : r_cnt_slow + SW'(1);
  assign w_fast_nxt = !w_ge_fast ? '0 : (r_cnt_fast == FAST_P_C) ? r_cnt_fast : r_cnt_fast + FW'(1);
  assign w_down_nxt = !w_below   ? '0 : (r_cnt_down == DOWN_P_C) ? r_cnt_down : r_cnt_down + NW'(1);

  always_comb begin
    w_state_d = r_state;
    w_slow_d  = r_cnt_slow;
    w_fast_d  = r_cnt_fast;
    w_down_d  = r_cnt_down;
    if (w_mode != AUTO) begin
      w_state_d = forced_state(w_mode);
      w_slow_d  = '0;
      w_fast_d  = '0;
      w_down_d  = '0;
    end else if (w_tick) begin
      w_slow_d = w_slow_nxt;
      w_fast_d = w_fast_nxt;
      w_down_d = w_down_nxt;
      if (w_fast_nxt == FAST_P_C) begin
        w_state_d = FAST;
      end else begin
        case (r_state)
          OFF: if (w_slow_nxt == SLOW_P_C) w_state_d = SLOW;
          SLOW: if (w_down_nxt == DOWN_P_C) begin
            w_state_d = OFF;
            w_down_d  = '0;
          end
          FAST: if (w_down_nxt == DOWN_P_C) begin
            w_state_d = SLOW;
            w_down_d  = '0;
          end
          default: w_state_d = OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state    <= OFF;
      r_cnt_slow <= '0;
      r_cnt_fast <= '0;
      r_cnt_down <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt_slow <= w_slow_d;
      r_cnt_fast <= w_fast_d;
      r_cnt_down <= w_down_d;
    end
  end

  assign num_drops   = w_num;
  assign sample_tick = w_tick;
  assign state       = r_state;
  assign wipe_slow   = (r_state == SLOW);
  assign wipe_fast   = (r_state == FAST);

endmodule

// File: tb/tb_wiper_ctrl.sv
// Directed bench for wiper_ctrl: default build plus a 12-sensor, divide-by-1 build.
module tb_wiper_ctrl;

  logic        clk_2 = 1'b0;
  logic        reset;
  logic [6:0]  drops;
  logic [1:0]  mode;
  logic [2:0]  num_drops;
  logic        sample_tick, wipe_slow, wipe_fast;
  logic [1:0]  state;

  logic [11:0] drops2;
  logic [3:0]  num_drops2;
  logic        sample_tick2, wipe_slow2, wipe_fast2;
  logic [1:0]  state2;

  int total = 0;
  int bad   = 0;

  always #5 clk_2 = ~clk_2;

  wiper_ctrl u_dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .drops       (drops),
    .mode        (mode),
    .num_drops   (num_drops),
    .sample_tick (sample_tick),
    .state       (state),
    .wipe_slow   (wipe_slow),
    .wipe_fast   (wipe_fast)
  );

  wiper_ctrl #(.N_SENS(12), .SAMPLE_DIV(1)) u_dut12 (
    .clk_2       (clk_2),
    .reset       (reset),
    .drops       (drops2),
    .mode        (2'b00),
    .num_drops   (num_drops2),
    .sample_tick (sample_tick2),
    .state       (state2),
    .wipe_slow   (wipe_slow2),
    .wipe_fast   (wipe_fast2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges (n rising edges), then settle 1 time unit.
  task automatic adv(input int n);
    repeat (n) @(negedge clk_2);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; drops = '0; drops2 = 12'h0A5;
    adv(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_wslow", 32'(wipe_slow), 0);
    chk("rst_wfast", 32'(wipe_fast), 0);
    chk("rst_tick", 32'(sample_tick), 0);
    chk("rst_tick_div1", 32'(sample_tick2), 1);
    chk("pop12_0a5", 32'(num_drops2), 4);
    drops2 = 12'hFFF; #1;
    chk("pop12_fff", 32'(num_drops2), 12);
    drops2 = '0;
    drops = 7'b0001111; #1;
    chk("pop_4", 32'(num_drops), 4);
    reset = 1'b0;                                   // k = 0
    adv(1); chk("first_tick", 32'(sample_tick), 1); // k = 1
    adv(4); chk("slow_k5_off", 32'(state), 0);      // k = 5
    adv(1);                                         // k = 6
    chk("slow_k6", 32'(state), 1);
    chk("slow_wslow", 32'(wipe_slow), 1);
    chk("slow_wfast", 32'(wipe_fast), 0);
    chk("tick_k6", 32'(sample_tick), 0);

    mode = 2'b01;
    adv(1); chk("force_off", 32'(state), 0);        // k = 7
    adv(1); mode = 2'b00; drops = 7'b0111111; #1;   // k = 8
    chk("pop_6", 32'(num_drops), 6);
    adv(2); chk("fast_k10_off", 32'(state), 0);
    adv(1); chk("fast_k11_off", 32'(state), 0);
    adv(1);                                         // k = 12
    chk("fast_k12", 32'(state), 2);
    chk("fast_wfast", 32'(wipe_fast), 1);
    chk("fast_wslow", 32'(wipe_slow), 0);

    drops = 7'b0000111;
    adv(2); chk("dn_k14_fast", 32'(state), 2);
    adv(2); chk("dn_k16_slow", 32'(state), 1);
    adv(2); chk("dn_k18_slow", 32'(state), 1);
    adv(2); chk("dn_k20_off", 32'(state), 0);

    mode = 2'b10;
    adv(1); chk("force_slow", 32'(state), 1);       // k = 21
    adv(1); mode = 2'b00; drops = '0;               // k = 22
    adv(2); chk("alt_k24", 32'(state), 1); drops = 7'b0001111;
    adv(2); chk("alt_k26", 32'(state), 1); drops = '0;
    adv(2); chk("alt_k28", 32'(state), 1); drops = 7'b0001111;
    adv(2); chk("alt_k30", 32'(state), 1); drops = '0;
    adv(2); chk("alt_k32", 32'(state), 1);
    adv(2); chk("alt_k34_off", 32'(state), 0);

    // Heavy rain only on non-tick cycles must be ignored.
    drops = 7'b1111111; #1;
    chk("pop_7", 32'(num_drops), 7);
    adv(1); drops = '0;                             // k = 35
    adv(1); drops = 7'b1111111;                     // k = 36
    adv(1); drops = '0;                             // k = 37
    adv(1); chk("between_ignored", 32'(state), 0);  // k = 38

    mode = 2'b11;
    adv(1); chk("force_fast", 32'(state), 2);       // k = 39
    adv(1); mode = 2'b00;                           // k = 40
    adv(3); chk("decay_k43_fast", 32'(state), 2);
    adv(1); chk("decay_k44_slow", 32'(state), 1);
    adv(3); chk("decay_k47_slow", 32'(state), 1);
    adv(1); chk("decay_k48_off", 32'(state), 0);

    mode = 2'b11;
    adv(2); mode = 2'b00; drops = 7'b1111111;       // k = 50
    chk("pre_rst_fast", 32'(state), 2);
    adv(1);                                         // k = 51, mid-divide
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_wfast", 32'(wipe_fast), 0);
    chk("async_rst_tick", 32'(sample_tick), 0);
    drops = '0; drops2 = 12'hFFF;
    adv(1); reset = 1'b0; #1;                       // k' = 0
    chk("restart_tick0", 32'(sample_tick), 0);
    adv(1);                                         // k' = 1
    chk("restart_tick1", 32'(sample_tick), 1);
    chk("n12_k1_off", 32'(state2), 0);
    adv(1);                                         // k' = 2
    chk("restart_tick2", 32'(sample_tick), 0);
    chk("restart_state", 32'(state), 0);
    chk("n12_k2_fast", 32'(state2), 2);
    chk("n12_wfast", 32'(wipe_fast2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
